// File: rtl/decoder_2x4.sv
// decoder_2x4: 2-to-4 one-hot decoder with registered copy and per-line saturating hit counters
module decoder_2x4 #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               A,
  input  logic               B,
  input  logic               E,
  input  logic               clr,
  output logic [3:0]         I,
  output logic [3:0]         I_q,
  output logic               E_q,
  output logic [4*CNT_W-1:0] hit_cnt,
  output logic [3:0]         cnt_sat
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [1:0] sel;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] sat_d;
  assign sel = {A, B};
  assign hit_cnt = cnt_q;
  // one-hot decode, purely combinational
  always_comb I = E ? 4'b0001 << sel : 4'b0000;
  // clr drops this cycle's hit; counters hold at all-ones and flag saturation on reaching it
  always_comb begin
    cnt_d = cnt_q;
    sat_d = '0;
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = clr ? '0 : (I[k] && cnt_q[k] != MAX) ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
      sat_d[k] = !clr && cnt_d[k] == MAX;
    end
  end
  // registered decode, strobe and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      I_q     <= '0;
      E_q     <= 1'b0;
      cnt_q   <= '0;
      cnt_sat <= '0;
    end else begin
      I_q     <= I;
      E_q     <= E;
      cnt_q   <= cnt_d;
      cnt_sat <= sat_d;
    end
  end
endmodule

// File: tb/tb_decoder_2x4.sv
// tb_decoder_2x4: directed vectors checked by a behavioural model plus literal expectations
module tb_decoder_2x4;
  logic clk = 0, rst, A, B, E, clr;
  logic [3:0] I8, I2, Iq8, Iq2, sat8, sat2;
  logic Eq8, Eq2;
  logic [31:0] hc8;
  logic [7:0] hc2;
  int n_tests = 0, n_fail = 0;
  bit armed = 0;
  int m8[4], m2[4];
  logic [3:0] ms8, ms2, m_iq;
  logic m_eq;
  int sel;

  decoder_2x4 #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .A(A), .B(B), .E(E), .clr(clr),
    .I(I8), .I_q(Iq8), .E_q(Eq8), .hit_cnt(hc8), .cnt_sat(sat8));
  decoder_2x4 #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .A(A), .B(B), .E(E), .clr(clr),
    .I(I2), .I_q(Iq2), .E_q(Eq2), .hit_cnt(hc2), .cnt_sat(sat2));

  always #5 clk = ~clk;
  assign sel = 2 * int'(A) + int'(B);

  function automatic logic [3:0] exp_i();
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k] = E && (k == sel);
    return r;
  endfunction

  task automatic check(input string nm, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, req);
    end
  endtask

  // reference model: integer counters clamped at 2^W-1
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m8[k] <= 0;
        m2[k] <= 0;
      end
      ms8 <= '0; ms2 <= '0; m_iq <= '0; m_eq <= 0; armed <= 1;
    end else begin
      m_iq <= exp_i();
      m_eq <= E;
      if (clr) begin
        for (int k = 0; k < 4; k++) begin
          m8[k] <= 0;
          m2[k] <= 0;
        end
        ms8 <= '0; ms2 <= '0;
      end else if (E) begin
        m8[sel] <= (m8[sel] + 1 > 255) ? 255 : m8[sel] + 1;
        m2[sel] <= (m2[sel] + 1 > 3) ? 3 : m2[sel] + 1;
        if (m8[sel] + 1 >= 255) ms8[sel] <= 1;
        if (m2[sel] + 1 >= 3) ms2[sel] <= 1;
      end
    end
  end

  always @(negedge clk) if (armed) begin
    check("I8", I8, exp_i());
    check("I2", I2, exp_i());
    check("I_q8", Iq8, m_iq);
    check("I_q2", Iq2, m_iq);
    check("E_q8", Eq8, m_eq);
    check("E_q2", Eq2, m_eq);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cnt8[%0d]", k), hc8[k*8 +: 8], m8[k]);
      check($sformatf("cnt2[%0d]", k), hc2[k*2 +: 2], m2[k]);
    end
    check("sat8", sat8, ms8);
    check("sat2", sat2, ms2);
  end

  task automatic cyc(input logic a, b, e, c, r);
    A = a; B = b; E = e; clr = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    automatic logic [3:0] oh[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    automatic int sat_seq[5] = '{1, 2, 3, 3, 3};
    automatic logic [1:0] s;
    cyc(1, 1, 1, 0, 1);
    cyc(1, 1, 1, 0, 1);
    check("rst_I", I8, 4'b1000);
    check("rst_I_q", Iq8, 0);
    check("rst_E_q", Eq8, 0);
    check("rst_cnt", hc8, 0);
    check("rst_sat", sat2, 0);
    for (int v = 0; v < 4; v++) begin
      s = 2'(v);
      cyc(s[1], s[0], 0, 0, 0);
      check("en_low_I", I8, 0);
      check("en_low_I_q", Iq8, 0);
    end
    check("en_low_cnt", hc8, 0);
    for (int v = 0; v < 4; v++) begin
      s = 2'(v);
      cyc(s[1], s[0], 1, 0, 0);
      check("sweep_I", I8, oh[v]);
      check("sweep_I_q", Iq8, oh[v]);
    end
    check("sweep_cnt8", hc8, 32'h01010101);
    check("sweep_cnt2", hc2, 8'b01010101);
    cyc(0, 0, 0, 1, 0);
    check("clr_cnt", hc8, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 0, 0);
      check("sat_cnt2", hc2[5:4], sat_seq[i]);
      check("sat_flag2", sat2[2], sat_seq[i] == 3);
      check("sat_others2", {hc2[7:6], hc2[3:0]}, 0);
      check("sat_cnt8", hc8[23:16], i + 1);
    end
    cyc(0, 1, 1, 1, 0);
    check("clrpri_cnt8", hc8, 0);
    check("clrpri_cnt2", hc2, 0);
    check("clrpri_sat", sat2, 0);
    check("clrpri_I_q", Iq8, 4'b0010);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 1);
    check("midrst_I", I8, 4'b0100);
    check("midrst_I_q", Iq8, 0);
    check("midrst_E_q", Eq8, 0);
    check("midrst_cnt", hc8, 0);
    cyc(1, 1, 1, 0, 0);
    check("resume_I_q", Iq8, 4'b1000);
    check("resume_E_q", Eq8, 1);
    check("resume_cnt", hc8, 32'h01000000);
    for (int i = 0; i < 260; i++) cyc(0, 0, 1, 0, 0);
    check("sat255_cnt", hc8[7:0], 255);
    check("sat255_flag", sat8, 4'b0001);
    for (int i = 0; i < 120; i++) cyc(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                                       1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 40) == 0));
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
